// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: sequences capture of one camera frame, or a stream of
// frames, into the pixel packer. It tracks line and pixel counts and flags
// frames whose size is wrong.
// Optional build macro CAPTURE_TIMEOUT_EN adds a watchdog that aborts a stalled
// capture after TIMEOUT pclk cycles. Without it, timeout is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// ARM     | waiting for the vsync frame gap so a partial frame is never taken
// SYNC    | in the frame gap, waiting for the vsync falling edge
// CAPTURE | frame active, pixel packer enabled, counting lines and pixels
// DONE    | one cycle: frame_done pulse, size check, frame counter update

module frame_capture_ctrl #(
   parameter int AW      = 15,
   parameter int H_PIX   = 160,
   parameter int V_LINES = 120,
   parameter int TIMEOUT = 2000000
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          cont,
   input  logic          vsync,
   input  logic          href,
   input  logic          px_wr,
   output logic          cap_en,
   output logic          busy,
   output logic          frame_done,
   output logic          frame_err,
   output logic          timeout,
   output logic [7:0]    line_cnt,
   output logic [AW-1:0] px_cnt,
   output logic [7:0]    frame_cnt
);

   localparam logic [AW-1:0] PX_FULL   = AW'(H_PIX * V_LINES);
   localparam logic [7:0]    LINES_EXP = 8'(V_LINES);

   typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

   state_t state, state_next;
   logic   vsync_q, href_q, cont_q;
   logic   vsync_fall, vsync_rise, href_fall;
   logic   start_ok, done_ok, wd_tc;

   assign vsync_fall = vsync_q & ~vsync;
   assign vsync_rise = ~vsync_q & vsync;
   assign href_fall  = href_q & ~href;
   assign start_ok   = (state == IDLE) && start && !stop;
   assign done_ok    = (state == DONE) && !stop;
   assign busy       = (state != IDLE);
   assign frame_done = done_ok;

`ifdef CAPTURE_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);

   logic [WDW-1:0] wd_cnt;
   logic           wd_run, timeout_q;

   assign wd_run  = (state == ARM) || (state == SYNC) || (state == CAPTURE);
   assign wd_tc   = wd_run && (wd_cnt == '0);
   assign timeout = timeout_q;

   // watchdog down-counter, reloaded on every state change and outside watched states
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         wd_cnt <= WD_LOAD;
      end else if (!wd_run || (state_next != state)) begin
         wd_cnt <= WD_LOAD;
      end else if (wd_cnt != '0) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end

   // sticky timeout flag, cleared by a new start; stop wins over the watchdog
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (start_ok) begin
         timeout_q <= 1'b0;
      end else if (wd_tc && !stop) begin
         timeout_q <= 1'b1;
      end
   end
`else
   assign wd_tc   = 1'b0;
   assign timeout = 1'b0;
`endif

   // state register plus the registered sync inputs used for edge detection
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
      end else begin
         state   <= state_next;
         vsync_q <= vsync;
         href_q  <= href;
      end
   end

   // next-state logic; stop overrides everything, then the watchdog
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = ARM;
         ARM:     if (vsync) state_next = SYNC;
         SYNC:    if (vsync_fall) state_next = CAPTURE;
         CAPTURE: if (vsync_rise) state_next = DONE;
         DONE:    state_next = cont_q ? SYNC : IDLE;
         default: state_next = IDLE;
      endcase
      if ((state != IDLE) && stop) begin
         state_next = IDLE;
      end else if (wd_tc) begin
         state_next = IDLE;
      end
   end

   // packer gate: rises one cycle after entering CAPTURE, falls with any exit
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cap_en <= 1'b0;
      end else begin
         cap_en <= (state == CAPTURE) && (state_next == CAPTURE);
      end
   end

   // line/pixel/frame counters and the sticky size-error flag
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cont_q    <= 1'b0;
         px_cnt    <= '0;
         line_cnt  <= '0;
         frame_cnt <= '0;
         frame_err <= 1'b0;
      end else if (start_ok) begin
         cont_q    <= cont;
         px_cnt    <= '0;
         line_cnt  <= '0;
         frame_err <= 1'b0;
      end else if ((state == SYNC) && (state_next == CAPTURE)) begin
         px_cnt   <= '0;
         line_cnt <= '0;
      end else if (state == CAPTURE) begin
         if (px_wr) begin
            if (px_cnt == PX_FULL) begin
               frame_err <= 1'b1;
            end else begin
               px_cnt <= px_cnt + 1'b1;
            end
         end
         if (href_fall && (line_cnt != 8'hFF)) begin
            line_cnt <= line_cnt + 8'd1;
         end
      end else if (done_ok) begin
         frame_cnt <= frame_cnt + 8'd1;
         if ((line_cnt != LINES_EXP) || (px_cnt != PX_FULL)) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with H_PIX=4, V_LINES=3, TIMEOUT=64.
module tb_frame_capture_ctrl;

   logic        pclk = 1'b0;
   logic        rst;
   logic        start, stop, cont, vsync, href, px_wr;
   logic        cap_en, busy, frame_done, frame_err, timeout;
   logic [7:0]  line_cnt, frame_cnt;
   logic [14:0] px_cnt;

   int n_cmp = 0;
   int n_err = 0;

   frame_capture_ctrl #(.AW(15), .H_PIX(4), .V_LINES(3), .TIMEOUT(64)) dut (
      .pclk(pclk), .rst(rst), .start(start), .stop(stop), .cont(cont),
      .vsync(vsync), .href(href), .px_wr(px_wr), .cap_en(cap_en), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err), .timeout(timeout),
      .line_cnt(line_cnt), .px_cnt(px_cnt), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic st, sp, ct, vs, hr, pw;
      logic ce, bz, fd, fe;
      int   px, ln, fc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic st, sp, ct, vs, hr, pw, ce, bz, fd,
                               input int px, ln, fc, input logic fe);
      vec_t v;
      v.st = st; v.sp = sp; v.ct = ct; v.vs = vs; v.hr = hr; v.pw = pw;
      v.ce = ce; v.bz = bz; v.fd = fd; v.px = px; v.ln = ln; v.fc = fc; v.fe = fe;
      return v;
   endfunction

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_frame(input int nl, input int ppl, input int extra);
      vsync = 1'b0; href = 1'b0; px_wr = 1'b0;
      tick();
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < ppl + ((l == nl - 1) ? extra : 0); p++) begin
            href = 1'b1; px_wr = 1'b1;
            tick();
         end
         href = 1'b0; px_wr = 1'b0;
         tick();
      end
      vsync = 1'b1;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int fd_seen;
      int early_cap;
      rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
      vsync = 1'b1; href = 1'b0; px_wr = 1'b0;

      // single good frame, one vector per cycle
      vq.push_back(mk(1,0,0,1,0,0, 0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,1,0,0, 0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,0,0,0, 0,1,0, 0,0,0,0));
      for (int l = 0; l < 3; l++) begin
         for (int p = 0; p < 4; p++)
            vq.push_back(mk(0,0,0,0,1,1, 1,1,0, l*4+p+1, l, 0, 0));
         vq.push_back(mk(0,0,0,0,0,0, 1,1,0, l*4+4, l+1, 0, 0));
      end
      vq.push_back(mk(0,0,0,1,0,0, 0,1,1, 12,3,0,0));
      vq.push_back(mk(0,0,0,1,0,0, 0,0,0, 12,3,1,0));

      tick(); tick();
      chk("reset_outputs",
          int'({cap_en, busy, frame_done, frame_err, timeout, line_cnt, px_cnt, frame_cnt}), 0);
      rst = 1'b0;
      tick();

      foreach (vq[i]) begin
         start = vq[i].st; stop = vq[i].sp; cont = vq[i].ct;
         vsync = vq[i].vs; href = vq[i].hr; px_wr = vq[i].pw;
         tick();
         n_cmp++;
         if (cap_en !== vq[i].ce || busy !== vq[i].bz || frame_done !== vq[i].fd ||
             frame_err !== vq[i].fe || int'(px_cnt) != vq[i].px ||
             int'(line_cnt) != vq[i].ln || int'(frame_cnt) != vq[i].fc) begin
            n_err++;
            $display("FAIL vec%0d: got ce=%0d bz=%0d fd=%0d fe=%0d px=%0d ln=%0d fc=%0d expected ce=%0d bz=%0d fd=%0d fe=%0d px=%0d ln=%0d fc=%0d",
                     i, cap_en, busy, frame_done, frame_err, px_cnt, line_cnt, frame_cnt,
                     vq[i].ce, vq[i].bz, vq[i].fd, vq[i].fe, vq[i].px, vq[i].ln, vq[i].fc);
         end
      end

      // start in the middle of a frame: nothing captured until a full gap passes
      vsync = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      early_cap = 0;
      for (int i = 0; i < 4; i++) begin
         href = 1'b1; px_wr = 1'b1;
         tick();
         if (cap_en) early_cap++;
      end
      href = 1'b0; px_wr = 1'b0;
      chk("midframe_no_cap", early_cap, 0);
      chk("midframe_px_ignored", int'(px_cnt), 0);
      chk("midframe_busy", int'(busy), 1);
      vsync = 1'b1;
      tick();
      do_frame(3, 4, 0);
      chk("midframe_done", int'(frame_done), 1);
      tick();
      chk("midframe_px", int'(px_cnt), 12);
      chk("midframe_err", int'(frame_err), 0);
      chk("midframe_fc", int'(frame_cnt), 2);

      // short frame: two lines only
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      do_frame(2, 4, 0);
      chk("short_done", int'(frame_done), 1);
      tick();
      chk("short_err", int'(frame_err), 1);
      chk("short_px", int'(px_cnt), 8);
      chk("short_ln", int'(line_cnt), 2);
      chk("short_fc", int'(frame_cnt), 3);

      // overrun: 13 pixel writes saturate at 12
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_clears_err", int'(frame_err), 0);
      tick();
      do_frame(3, 4, 1);
      tick();
      chk("over_px", int'(px_cnt), 12);
      chk("over_err", int'(frame_err), 1);
      chk("over_fc", int'(frame_cnt), 4);

      // continuous mode: three frames, then stop mid-capture
      cont = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; cont = 1'b0;
      tick();
      for (int f = 0; f < 3; f++) begin
         do_frame(3, 4, 0);
         chk($sformatf("cont_done%0d", f), int'(frame_done), 1);
         tick();
         chk($sformatf("cont_busy%0d", f), int'({busy, frame_done}), 2);
         chk($sformatf("cont_fc%0d", f), int'(frame_cnt), 5 + f);
      end
      chk("cont_err", int'(frame_err), 0);
      vsync = 1'b0;
      tick();
      href = 1'b1; px_wr = 1'b1;
      tick(); tick();
      chk("cont_cap_on", int'(cap_en), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0; href = 1'b0; px_wr = 1'b0;
      chk("stop_idle", int'({busy, cap_en, frame_done}), 0);
      chk("stop_fc", int'(frame_cnt), 7);

      // reset in the middle of a capture
      vsync = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      vsync = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         href = 1'b1; px_wr = 1'b1;
         tick();
      end
      chk("rst_pre_px", int'(px_cnt), 5);
      chk("rst_pre_cap", int'(cap_en), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_cap", int'(cap_en), 0);
      chk("rst_async_cnts", int'({line_cnt, px_cnt, frame_cnt, busy}), 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("rst_after_px", int'(px_cnt), 0);
      chk("rst_after_state", int'({busy, cap_en}), 0);
      href = 1'b0; px_wr = 1'b0;

      // vsync stuck low after start
      start = 1'b1;
      tick();
      start = 1'b0;
      fd_seen = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (frame_done) fd_seen++;
      end
      chk("stuck_no_done", fd_seen, 0);
`ifdef CAPTURE_TIMEOUT_EN
      chk("stuck_timeout", int'(timeout), 1);
      chk("stuck_idle", int'(busy), 0);
`else
      chk("stuck_timeout", int'(timeout), 0);
      chk("stuck_busy", int'(busy), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stuck_stop", int'(busy), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
